hmmm_mem_target: RTL and testbench



---
 rtl/hmmm_mem_pkg.sv | 17 +
 rtl/hmmm_out_fifo.sv | 76 +++++++
 rtl/hmmm_mem_target.sv | 143 ++++++++++++++
 tb/tb_hmmm_mem_target.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_mem_pkg.sv
// Shared definitions for the HMMM memory target: loader states, IO address
// and the layout of the status word returned on reads of the IO address.
package hmmm_mem_pkg;

  typedef enum logic [1:0] {
    GET_HI = 2'd0,
    GET_LO = 2'd1,
    RUN    = 2'd2
  } load_state_t;

  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

  localparam int unsigned STAT_CNT_LSB = 0;
  localparam int unsigned STAT_CNT_W   = 3;
  localparam int unsigned STAT_OVF_BIT = 3;

endpackage

// File: rtl/hmmm_out_fifo.sv
// First-word-fall-through output FIFO built from two-phase flops
// (D captured at the end of ph2, Q updated on ph1).
module hmmm_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         ph1,
  input  logic                         ph2,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop_req,
  output logic                         out_valid,
  output logic                         full,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_m, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_m, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_m, cnt_d;
  logic             we_m;
  logic [PW-1:0]    wa_m;
  logic [WIDTH-1:0] wd_m;
  logic             pop_ok, push_ok;

  assign out_valid = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign pop_ok    = pop_req && out_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop_ok);
  assign count     = cnt_q;
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(negedge ph2) begin
    if (reset) begin
      rd_ptr_m <= '0;
      wr_ptr_m <= '0;
      cnt_m    <= '0;
      we_m     <= 1'b0;
    end else begin
      rd_ptr_m <= rd_ptr_d;
      wr_ptr_m <= wr_ptr_d;
      cnt_m    <= cnt_d;
      we_m     <= push_ok;
    end
    wa_m <= wr_ptr_q;
    wd_m <= push_data;
  end

  always_ff @(posedge ph1) begin
    rd_ptr_q <= rd_ptr_m;
    wr_ptr_q <= wr_ptr_m;
    cnt_q    <= cnt_m;
  end

  always_ff @(posedge ph1) begin
    if (we_m) mem[wa_m] <= wd_m;
  end

endmodule

// File: rtl/hmmm_mem_target.sv
// Memory responder for the HMMM core: byte-serial program loader, word array
// serving fetches/loads/stores, and a memory-mapped output FIFO.
module hmmm_mem_target
  import hmmm_mem_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 8,
  parameter int unsigned             DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]   IO_ADDR    = ADDR_WIDTH'(IO_ADDR_DEFAULT),
  parameter int unsigned             OUT_DEPTH  = 4
) (
  input  logic                  ph1,
  input  logic                  ph2,
  input  logic                  reset,
  output logic                  cpu_reset,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic                  cpu_mem_write,
  input  logic [7:0]            cpu_wr_data,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [7:0]            load_data,
  input  logic                  load_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  overflow,
  output logic                  running
);

  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  load_state_t           state_q, state_m, state_d;
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_m, ld_addr_d;
  logic [7:0]            hi_q, hi_m, hi_d;
  logic                  ovf_q, ovf_m, ovf_d;

  logic                  arr_we, arr_we_m;
  logic [ADDR_WIDTH-1:0] arr_wa, arr_wa_m;
  logic [DATA_WIDTH-1:0] arr_wd, arr_wd_m;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                  load_accept, core_store, io_store, fifo_full, fifo_pop;
  logic [CW-1:0]         fifo_count;
  logic [2:0]            cnt3;
  logic [DATA_WIDTH-1:0] status;

  always_ff @(negedge ph2) begin
    if (reset) begin
      state_m   <= GET_HI;
      ld_addr_m <= '0;
      hi_m      <= '0;
      ovf_m     <= 1'b0;
      arr_we_m  <= 1'b0;
    end else begin
      state_m   <= state_d;
      ld_addr_m <= ld_addr_d;
      hi_m      <= hi_d;
      ovf_m     <= ovf_d;
      arr_we_m  <= arr_we;
    end
    arr_wa_m <= arr_wa;
    arr_wd_m <= arr_wd;
  end

  always_ff @(posedge ph1) begin
    state_q   <= state_m;
    ld_addr_q <= ld_addr_m;
    hi_q      <= hi_m;
    ovf_q     <= ovf_m;
  end

  always_ff @(posedge ph1) begin
    if (arr_we_m) mem[arr_wa_m] <= arr_wd_m;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_HI:  if (load_accept) state_d = GET_LO;
      GET_LO:  if (load_accept) state_d = load_last ? RUN : GET_HI;
      RUN:     state_d = RUN;
      default: state_d = GET_HI;
    endcase
  end

  always_comb begin
    load_ready = (state_q != RUN);
    cpu_reset  = (state_q != RUN);
    running    = (state_q == RUN);
  end

  assign load_accept = load_valid && load_ready;
  assign core_store  = running && cpu_mem_write;
  assign io_store    = core_store && (cpu_adr == IO_ADDR);
  assign fifo_pop    = out_valid && out_ready;
  assign ovf_d       = ovf_q || (io_store && fifo_full && !fifo_pop);
  assign overflow    = ovf_q;

  // Loader and core never write in the same cycle: core stores need RUN.
  always_comb begin
    hi_d      = hi_q;
    ld_addr_d = ld_addr_q;
    arr_we    = 1'b0;
    arr_wa    = cpu_adr;
    arr_wd    = DATA_WIDTH'(cpu_wr_data);
    if (state_q == GET_HI && load_accept) hi_d = load_data;
    if (state_q == GET_LO && load_accept) begin
      arr_we    = 1'b1;
      arr_wa    = ld_addr_q;
      arr_wd    = DATA_WIDTH'({hi_q, load_data});
      ld_addr_d = ld_addr_q + 1'b1;
    end else if (core_store && cpu_adr != IO_ADDR) begin
      arr_we = 1'b1;
    end
  end

  always_comb begin
    cnt3   = 3'(fifo_count);
    status = '0;
    status[STAT_CNT_LSB +: STAT_CNT_W] = cnt3;
    status[STAT_OVF_BIT]               = ovf_q;
    if (cpu_mem_write)          cpu_rd_data = '0;
    else if (cpu_adr == IO_ADDR) cpu_rd_data = status;
    else                         cpu_rd_data = mem[cpu_adr];
  end

  hmmm_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (8)
  ) u_out_fifo (
    .ph1       (ph1),
    .ph2       (ph2),
    .reset     (reset),
    .push      (io_store),
    .push_data (cpu_wr_data),
    .pop_req   (out_ready),
    .out_valid (out_valid),
    .full      (fifo_full),
    .out_data  (out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_hmmm_mem_target.sv
// Scoreboard bench for hmmm_mem_target: stimulus updates a behavioural model
// and queues expectations; a monitor compares them against the DUT each cycle.
module tb_hmmm_mem_target;

  logic        ph1 = 1'b0, ph2 = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_reset, load_ready, out_valid, overflow, running;
  logic [7:0]  cpu_adr = '0, cpu_wr_data = '0, load_data = '0, out_data;
  logic        cpu_mem_write = 1'b0, load_valid = 1'b0, load_last = 1'b0, out_ready = 1'b0;
  logic [15:0] cpu_rd_data;

  hmmm_mem_target #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .IO_ADDR    (8'hFF),
    .OUT_DEPTH  (4)
  ) dut (
    .ph1           (ph1),
    .ph2           (ph2),
    .reset         (reset),
    .cpu_reset     (cpu_reset),
    .cpu_adr       (cpu_adr),
    .cpu_mem_write (cpu_mem_write),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_rd_data   (cpu_rd_data),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last     (load_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .overflow      (overflow),
    .running       (running)
  );

  // Non-overlapping two-phase clock, 40-unit cycle.
  initial forever begin
    #5  ph1 = 1'b1;
    #10 ph1 = 1'b0;
    #10 ph2 = 1'b1;
    #10 ph2 = 1'b0;
    #5;
  end

  typedef struct {
    bit run;
    bit ovf;
    bit ovalid;
  } ctl_t;

  ctl_t        ctl_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  out_q[$];
  bit          rd_chk = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // Reference model state
  bit          m_valid = 1'b0, m_run, m_phase, m_ovf;
  int          m_cnt;
  logic [7:0]  m_addr, m_hi;
  logic [15:0] mm [256];
  bit          kn [256];

  // Requested drive values for the next cycle
  bit          d_reset = 1'b1, d_we = 1'b0, d_lv = 1'b0, d_ll = 1'b0, d_or = 1'b0;
  logic [7:0]  d_adr = '0, d_wd = '0, d_ld = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit run_pre, pop, push;
    @(posedge ph1);
    #2;
    reset = d_reset; cpu_adr = d_adr; cpu_mem_write = d_we; cpu_wr_data = d_wd;
    load_valid = d_lv; load_data = d_ld; load_last = d_ll; out_ready = d_or;
    rd_chk = 1'b0;
    if (m_valid) begin
      ctl_t c;
      c.run = m_run; c.ovf = m_ovf; c.ovalid = (m_cnt != 0);
      ctl_q.push_back(c);
      if (d_we) begin
        rd_q.push_back(16'h0000); rd_chk = 1'b1;
      end else if (d_adr == 8'hFF) begin
        rd_q.push_back({8'h00, 4'h0, m_ovf, 3'(m_cnt)}); rd_chk = 1'b1;
      end else if (kn[d_adr]) begin
        rd_q.push_back(mm[d_adr]); rd_chk = 1'b1;
      end
    end
    if (d_reset) begin
      m_valid = 1'b1; m_run = 1'b0; m_phase = 1'b0; m_addr = '0; m_hi = '0;
      m_ovf = 1'b0; m_cnt = 0; out_q.delete();
    end else if (m_valid) begin
      run_pre = m_run;
      pop  = (m_cnt > 0) && d_or;
      push = run_pre && d_we && (d_adr == 8'hFF);
      if (!run_pre && d_lv) begin
        if (!m_phase) begin
          m_hi = d_ld; m_phase = 1'b1;
        end else begin
          mm[m_addr] = {m_hi, d_ld}; kn[m_addr] = 1'b1;
          m_addr = m_addr + 8'd1; m_phase = 1'b0;
          if (d_ll) m_run = 1'b1;
        end
      end
      if (run_pre && d_we && d_adr != 8'hFF) begin
        mm[d_adr] = {8'h00, d_wd}; kn[d_adr] = 1'b1;
      end
      if (push) begin
        if (m_cnt < 4 || pop) begin
          out_q.push_back(d_wd); m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop) m_cnt--;
    end
  endtask

  initial forever begin
    @(posedge ph1);
    #15;
    if (ctl_q.size() > 0) begin
      ctl_t c;
      c = ctl_q.pop_front();
      chk("running",    {31'd0, running},    {31'd0, c.run});
      chk("cpu_reset",  {31'd0, cpu_reset},  {31'd0, !c.run});
      chk("load_ready", {31'd0, load_ready}, {31'd0, !c.run});
      chk("overflow",   {31'd0, overflow},   {31'd0, c.ovf});
      chk("out_valid",  {31'd0, out_valid},  {31'd0, c.ovalid});
      if (!c.ovalid) chk("out_data_idle", {24'd0, out_data}, 32'd0);
    end
    if (rd_chk && rd_q.size() > 0) begin
      chk("cpu_rd_data", {16'd0, cpu_rd_data}, {16'd0, rd_q.pop_front()});
      rd_chk = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) chk("fifo_pop_unexpected", 32'd1, 32'd0);
      else chk("fifo_out_data", {24'd0, out_data}, {24'd0, out_q.pop_front()});
    end
  end

  task automatic idle(input int n);
    d_we = 1'b0; d_lv = 1'b0; d_ll = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    d_reset = 1'b1; d_or = 1'b0; d_we = 1'b0; d_lv = 1'b0; d_ll = 1'b0;
    for (int i = 0; i < n; i++) step();
    d_reset = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b, input bit last);
    d_lv = 1'b1; d_ld = b; d_ll = last; d_we = 1'b0;
    step();
    d_lv = 1'b0; d_ll = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    d_we = 1'b0; d_lv = 1'b0; d_adr = a;
    step();
  endtask

  task automatic st(input logic [7:0] a, input logic [7:0] v);
    d_we = 1'b1; d_adr = a; d_wd = v;
    step();
    d_we = 1'b0;
  endtask

  initial begin
    do_reset(2);

    load_byte(8'h12, 1'b0);
    load_byte(8'h34, 1'b0);
    load_byte(8'hAB, 1'b0);
    load_byte(8'hCD, 1'b1);
    rd(8'h00);
    rd(8'h01);
    st(8'h10, 8'h2D);
    rd(8'h10);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) st(8'hFF, 8'h21 + 8'(i));
    d_or = 1'b1;
    st(8'hFF, 8'h25);
    d_or = 1'b0;
    rd(8'hFF);
    d_or = 1'b1;
    idle(4);
    d_or = 1'b0;
    rd(8'hFF);

    // Overflow on the fifth store with no pops
    for (int i = 1; i <= 5; i++) st(8'hFF, 8'(i));
    rd(8'hFF);
    d_or = 1'b1;
    idle(5);
    d_or = 1'b0;
    rd(8'hFF);

    for (int i = 0; i < 200; i++) begin
      int sel;
      sel   = $urandom_range(0, 3);
      d_or  = 1'($urandom_range(0, 1));
      d_we  = ($urandom_range(0, 2) != 0);
      d_wd  = 8'($urandom);
      d_adr = (sel < 2) ? 8'hFF : (sel == 2) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step();
    end
    d_we = 1'b0; d_or = 1'b1;
    idle(6);
    d_or = 1'b0;

    // Reset mid-load discards the pending high byte and restarts at 0
    do_reset(1);
    load_byte(8'h77, 1'b0);
    do_reset(1);
    load_byte(8'hBE, 1'b0);
    load_byte(8'hEF, 1'b1);
    rd(8'h00);
    rd(8'h01);

    // 257 words wrap the load address; core stores while held in reset are ignored
    do_reset(1);
    for (int w = 0; w < 257; w++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          d_lv = 1'b0; d_we = 1'b1;
          d_adr = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 3));
          d_wd = 8'($urandom);
          step();
        end
        d_lv  = 1'b1;
        d_ld  = 8'($urandom);
        d_ll  = (b == 0) ? 1'($urandom_range(0, 1)) : (w == 256);
        d_we  = 1'($urandom_range(0, 1));
        d_adr = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 3));
        d_wd  = 8'($urandom);
        step();
      end
    end
    d_lv = 1'b0; d_ll = 1'b0; d_we = 1'b0;
    rd(8'h00);
    rd(8'h01);
    rd(8'h80);
    rd(8'hFF);
    idle(2);

    chk("scoreboard_drained", out_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
